seq_display: RTL
================

# seq_display

Multi-digit, parametrised successor to the two-digit combinational binary display path. It accepts an unsigned binary value over a valid/ready handshake and converts it to BCD with an iterative shift-add-3 (double-dabble) engine, one bit per cycle. It then drives registered, active-low seven-segment patterns for `NDIGITS` digits, with optional leading-zero blanking. It sits between the calculator datapath result and the board's seven-segment displays.

## Interface
- `NBITS`, default 8: input width; legal range 1..16.
- `NDIGITS`, default 3: digit count; must satisfy 10^NDIGITS > 2^NBITS − 1, otherwise elaboration fails.
- `BLANK_LZ`, default 1: 1 = blank leading zero digits; 0 = show all digits.
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk`, input, 1: clock. All state changes on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `in_val`, input, 1: `in` is valid.
- `in_rdy`, output, 1: the block can accept a value.
- `in`, input, NBITS: unsigned binary value.
- `out_val`, output, 1: one-cycle pulse when `seg` and `bcd` update.
- `bcd`, output, 4·NDIGITS: registered BCD result; digit 0 (ones) in bits [3:0].
- `seg`, output, 7·NDIGITS: registered active-low segments; digit i in bits [7i+6:7i], with bit 0 = a through bit 6 = g.

## Operation
- States:
  - IDLE: `in_rdy`=1.
  - CONV: `in_rdy`=0; a bit counter runs 0..NBITS−1.
- Handshake: a transfer occurs on an edge where `in_val` && `in_rdy`.
  - The block captures `in` into the shift register, clears the BCD accumulator and moves to CONV.
  - When `in_val`=1 and `in_rdy`=0, the input is ignored. No queueing.
- Conversion step (each CONV edge):
  - Every BCD nibble ≥5 gets +3.
  - Then {bcd, shift} shifts left by one.
- After the step where the counter reaches NBITS−1:
  - The BCD result and the decoded segments load into the `bcd`/`seg` registers.
  - `out_val` pulses and the state returns to IDLE.
- Decode: 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001, 5→0010010, 6→0000010, 7→1111000, 8→0000000, 9→0010000 (bits g..a).
- Blanking, when `BLANK_LZ`=1:
  - Digits above the most-significant nonzero digit show 1111111 (blank).
  - Digit 0 is never blanked, so an input of 0 shows "0".
  - `bcd` is never blanked.
- `seg`/`bcd` hold their previous result throughout CONV.
- Reset values:
  - State IDLE, `in_rdy`=1, `out_val`=0.
  - `bcd`=0.
  - `seg` all 1111111 (display dark).
- Reset during CONV: the conversion is aborted and the result is discarded. Outputs take their reset values and no `out_val` pulse is produced.

## Timing
- Acceptance edge k; conversion edges k+1..k+NBITS.
- `seg`, `bcd` and `out_val`=1 are visible in the cycle after edge k+NBITS.
- `in_rdy` is low for cycles k+1..k+NBITS and high again with `out_val`. The earliest next acceptance is edge k+NBITS+1.
- Throughput: one value per NBITS+1 cycles.
- `out_val` is high for exactly one cycle and coincides with `in_rdy` returning high.
- There is no combinational path from `in`/`in_val` to any output.

## Structure
- Package `display_pkg` holds:
  - the state enum (IDLE, CONV);
  - `SEG_BLANK` = 7'h7F;
  - the ten digit patterns as constants.
- Sub-module `seven_seg_decoder`: combinational, 4-bit digit plus blank flag in, 7-bit active-low pattern out. It is instantiated NDIGITS times in a generate loop.
- The top contains the FSM, counter, shift/add-3 datapath, blanking logic and output registers.

## Test plan
- After reset, with no input: `seg`=all 1111111, `bcd`=0, `in_rdy`=1, `out_val`=0.
- NBITS=8, NDIGITS=3, `BLANK_LZ`=1, in=255: after 8 conversion edges `bcd`=0x255 and `seg`={0100100,0010010,0010010}. `out_val` is exactly one cycle and `in_rdy` is low for 8 cycles.
- in=7, then in=0 (`BLANK_LZ`=1):
  - 7 → `seg`={1111111,1111111,1111000}.
  - 0 → {1111111,1111111,1000000}.
  - With `BLANK_LZ`=0, 7 → {1000000,1000000,1111000}.
- Offer in=100 during an in-progress conversion of 42: 100 is ignored. The result is 042, and in=100 is accepted only when `in_rdy`=1.
- Assert `rst` at the 4th conversion edge of in=199: outputs return to reset values and no `out_val` pulse occurs. After release, in=199 converts to `bcd`=0x199.
- NBITS=5, NDIGITS=2, exhaustive 0..31 with back-to-back `in_val`: `bcd` equals the decimal value of each input. Transfers occur exactly every 6 cycles.

Source files
------------

// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared types and segment constants for the BCD display path
package display_pkg;

  typedef enum logic {IDLE, CONV} state_t;

  // Active-low patterns, bit 6 = g down to bit 0 = a.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  function automatic longint unsigned pow10(input int n);
    longint unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// rtl/seven_seg_decoder.sv - one BCD digit to an active-low seven-segment pattern
module seven_seg_decoder
  import display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0: seg = SEG_0;
        4'd1: seg = SEG_1;
        4'd2: seg = SEG_2;
        4'd3: seg = SEG_3;
        4'd4: seg = SEG_4;
        4'd5: seg = SEG_5;
        4'd6: seg = SEG_6;
        4'd7: seg = SEG_7;
        4'd8: seg = SEG_8;
        4'd9: seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/seq_display.sv
// rtl/seq_display.sv - handshaked binary-to-BCD converter (double dabble) driving
// registered multi-digit seven-segment outputs with optional leading-zero blanking
module seq_display
  import display_pkg::*;
#(
  parameter int NBITS    = 8,
  parameter int NDIGITS  = 3,
  parameter int BLANK_LZ = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_val,
  output logic                   in_rdy,
  input  logic [NBITS-1:0]       in,
  output logic                   out_val,
  output logic [4*NDIGITS-1:0]   bcd,
  output logic [7*NDIGITS-1:0]   seg
);

  localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int BW = 4 * NDIGITS;
  localparam longint unsigned MAXV = (64'd1 << NBITS) - 64'd1;

  generate
    if (NBITS < 1 || NBITS > 16) begin : g_nbits_err
      $error("seq_display: NBITS must be within 1..16");
    end
    if (pow10(NDIGITS) <= MAXV) begin : g_ndigits_err
      $error("seq_display: NDIGITS too small to hold 2**NBITS-1");
    end
  endgenerate

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [NBITS-1:0] sh;
  logic [BW-1:0]    acc;
  logic [BW-1:0]    adj;
  logic [BW-1:0]    acc_next;
  logic [NBITS-1:0] sh_next;
  logic [NDIGITS-1:0]   blank;
  logic [7*NDIGITS-1:0] seg_next;

  // One double-dabble step: add 3 to nibbles >= 5, then shift {acc, sh} left.
  always_comb begin
    adj = acc;
    for (int i = 0; i < NDIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
    acc_next = (adj << 1) | {{(BW-1){1'b0}}, sh[NBITS-1]};
    sh_next  = sh << 1;
  end

  // A digit blanks only when it and every digit above it are zero; digit 0 never blanks.
  always_comb begin
    logic nz;
    nz    = 1'b0;
    blank = '0;
    for (int i = NDIGITS - 1; i >= 1; i--) begin
      nz       = nz | (acc_next[4*i +: 4] != 4'd0);
      blank[i] = (BLANK_LZ != 0) && !nz;
    end
  end

  for (genvar g = 0; g < NDIGITS; g++) begin : g_dec
    seven_seg_decoder u_dec (
      .digit (acc_next[4*g +: 4]),
      .blank (blank[g]),
      .seg   (seg_next[7*g +: 7])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      in_rdy  <= 1'b1;
      out_val <= 1'b0;
      cnt     <= '0;
      sh      <= '0;
      acc     <= '0;
      bcd     <= '0;
      seg     <= {NDIGITS{SEG_BLANK}};
    end else begin
      out_val <= 1'b0;
      case (state)
        IDLE: begin
          if (in_val) begin
            sh     <= in;
            acc    <= '0;
            cnt    <= '0;
            in_rdy <= 1'b0;
            state  <= CONV;
          end
        end
        CONV: begin
          sh  <= sh_next;
          acc <= acc_next;
          if (cnt == CW'(NBITS - 1)) begin
            bcd     <= acc_next;
            seg     <= seg_next;
            out_val <= 1'b1;
            in_rdy  <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
